vga_timing_gen: RTL and testbench

Generates VGA 640x480@60 raster timing. Drives the h_counter/v_counter pair consumed by the screen renderers (victory/defeat/game screens). Samples the renderer's combinational R/G/B back in, then registers pixel data, syncs and blanking aligned to each other for the DAC/connector. Sits between the 50 MHz board clock domain and the VGA output pins.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters for the renderers,
// and a one-pixel-late registered output stage (syncs, blank, RGB) for the DAC.
module vga_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic [9:0]  h_counter,
    output logic [9:0]  v_counter,
    output logic        video_on,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_n_q, blank_n_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic pix_tick;
    logic h_end;
    logic v_end;
    logic vis;

    assign pix_tick = (div_q == DIV_LAST);
    // >= rather than == so an out-of-range count still wraps instead of running away
    assign h_end    = (h_q >= H_LAST);
    assign v_end    = (v_q >= V_LAST);
    assign vis      = (h_q < H_VIS_C) && (v_q < V_VIS_C);

    always_comb begin
        div_d         = pix_tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_n_d     = blank_n_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        if (pix_tick) begin
            h_d = h_end ? 10'd0 : h_q + 10'd1;
            if (h_end) begin
                v_d = v_end ? 10'd0 : v_q + 10'd1;
            end
            // Output stage sees the pre-increment position, giving the one-pixel pin lag
            hsync_d   = !((h_q >= HS_START) && (h_q < HS_END));
            vsync_d   = !((v_q >= VS_START) && (v_q < VS_END));
            blank_n_d = vis;
            r_d       = vis ? R_in : 8'd0;
            g_d       = vis ? G_in : 8'd0;
            b_d       = vis ? B_in : 8'd0;
            if (h_end && v_end) begin
                frame_start_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign video_on    = vis;
    assign vga_clk     = (div_q >= DIV_HALF);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign R_out       = r_q;
    assign G_out       = g_q;
    assign B_out       = b_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, random RGB and random async resets,
// every output compared each clock against a position-arithmetic model.
module tb_vga_timing_gen;

    localparam int CD = 3;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  R_in = 8'd0, G_in = 8'd0, B_in = 8'd0;
    logic [9:0]  h_counter, v_counter;
    logic        video_on, vga_clk, hsync, vsync, blank_n, frame_start;
    logic [7:0]  R_out, G_out, B_out;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edges  = 0;
    logic [7:0] last_r = 8'd0, last_g = 8'd0, last_b = 8'd0;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .h_counter(h_counter), .v_counter(v_counter), .video_on(video_on),
        .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: after n clock edges since reset, k = n/CD pixels have elapsed and the
    // raster position is k modulo the frame size; pins show the position of tick k-1.
    task automatic check_model();
        int k, pos, h, v, p, hp, vp;
        logic e_hs, e_vs, e_bl, e_fs;
        logic [7:0] e_r, e_g, e_b;
        k   = n_edges / CD;
        pos = k % FR;
        h   = pos % HT;
        v   = pos / HT;
        if (k == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
            e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
        end else begin
            p  = (k - 1) % FR;
            hp = p % HT;
            vp = p / HT;
            e_hs = !(hp >= HV + HF && hp < HV + HF + HS);
            e_vs = !(vp >= VV + VF && vp < VV + VF + VS);
            e_bl = (hp < HV) && (vp < VV);
            e_r  = e_bl ? last_r : 8'd0;
            e_g  = e_bl ? last_g : 8'd0;
            e_b  = e_bl ? last_b : 8'd0;
        end
        e_fs = (k > 0) && (n_edges % CD == 0) && (pos == 0);
        check_val("h_counter",   32'(h_counter),   32'(h));
        check_val("v_counter",   32'(v_counter),   32'(v));
        check_val("video_on",    32'(video_on),    32'((h < HV) && (v < VV)));
        check_val("vga_clk",     32'(vga_clk),     32'((n_edges % CD) >= CD / 2));
        check_val("hsync",       32'(hsync),       32'(e_hs));
        check_val("vsync",       32'(vsync),       32'(e_vs));
        check_val("blank_n",     32'(blank_n),     32'(e_bl));
        check_val("R_out",       32'(R_out),       32'(e_r));
        check_val("G_out",       32'(G_out),       32'(e_g));
        check_val("B_out",       32'(B_out),       32'(e_b));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
        check_val("frame_count", 32'(frame_count), 32'((k / FR) % 65536));
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            n_edges = n_edges + 1;
            if (n_edges % CD == 0) begin
                last_r = R_in;
                last_g = G_in;
                last_b = B_in;
            end
        end
    end

    always @(negedge clk) check_model();

    task automatic run_clks(input int cycles, input bit fixed_rgb);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if (fixed_rgb) begin
                R_in = 8'hFF; G_in = 8'h00; B_in = 8'h80;
            end else begin
                R_in = 8'($urandom); G_in = 8'($urandom); B_in = 8'($urandom);
            end
        end
    endtask

    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #3;
        reset = 1'b1;
        n_edges = 0;
        #1;
        check_model();
        repeat (hold) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        run_clks(3 * FR * CD + 7, 1'b0);
        run_clks(FR * CD, 1'b1);
        for (int j = 0; j < 8; j++) begin
            pulse_reset(int'($urandom_range(1, 5)));
            run_clks(int'($urandom_range(20, 2 * FR * CD)), j[0]);
        end
        run_clks(2 * FR * CD, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
